usb_d_orig_gen: RTL and testbench
=================================

Name: usb_d_orig_gen

Overview:
- Serial USB-style line driver. Converts a parallel byte stream into NRZI-encoded, bit-stuffed differential levels on d_plus/d_minus.
- Sits between the packet/byte source (which holds `data` valid and `sending` high) and the bus pad drivers.
- Ends every transmission with an end-of-packet (EOP) sequence and returns the line to the idle J state.

Parameters:
- CLKS_PER_BIT, 8, clock cycles per transmitted bit period (must be ≥2).
- EOP_SE0_BITS, 2, bit periods of SE0 in the EOP.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- n_rst  in  1  reset; synchronous, active-high (n_rst=1 at a rising clk edge resets; name kept per codebase convention).
- sending  in  1  high = transmit; low = finish current byte, then send EOP.
- data  in  8  byte to transmit, LSB first; sampled at each byte boundary.
- d_plus  out  1  D+ line level.
- d_minus  out  1  D- line level.

Behaviour:
- Line states: J = (d_plus=1, d_minus=0); K = (0,1); SE0 = (0,0). The (1,1) state is never driven.
- Reset: d_plus=1, d_minus=0, FSM=IDLE, bit timer=0, ones counter=0, NRZI level=J. Reset has priority over everything, including mid-byte operation; J is driven on the edge after reset.
- FSM states and transitions:
  - IDLE → LOAD: sending=1 sampled.
  - LOAD: capture `data` into the shift register, bit index=0; go to SHIFT on the same edge.
  - SHIFT → STUFF: six consecutive 1s have been transmitted.
  - SHIFT → LOAD: after bit 7, if sending=1.
  - SHIFT → EOP_SE0: after bit 7, if sending=0 and no stuff bit is pending.
  - STUFF → SHIFT or EOP_SE0: same rules as leaving SHIFT.
  - EOP_SE0 → EOP_J → IDLE.
- Latency: sending sampled high at edge t → first bit level appears on the outputs after edge t+1. Each bit is held exactly CLKS_PER_BIT cycles.
- Back-to-back bytes: no gap between consecutive bytes. The next `data` is sampled on the edge that starts its bit 0.
- NRZI: data bit 0 toggles the line (J↔K); data bit 1 holds the previous level.
- Bit stuffing:
  - The ones counter increments on each transmitted 1 and clears on any 0 or stuffed bit.
  - When it reaches 6, exactly one stuffed 0 (a toggle) is inserted before the next data bit.
  - The counter persists across byte boundaries.
  - A pending stuff bit is still sent even when sending has dropped.
- Early stop: sending dropping mid-byte does not truncate the byte; all 8 bits are completed.
- EOP: SE0 for EOP_SE0_BITS×CLKS_PER_BIT cycles, then J for CLKS_PER_BIT cycles, then IDLE. Sending is ignored during EOP. IDLE resets the NRZI level to J and the ones counter to 0.
- Restart: sending=1 in IDLE restarts on the next edge.

Optional Feature:
- Macro: D_ORIG_SYNC_EN.
- With it defined: each transmission begins with the SYNC pattern 8'b1000_0000, sent LSB first and NRZI-encoded (KJKJKJKK). It is generated in a SYNC state between IDLE and the first LOAD. The first `data` byte is sampled at the end of SYNC. SYNC bits count toward the ones counter.
- Without it: IDLE goes directly to LOAD.

Test Plan:
- Reset: n_rst=1 for 1 cycle, then 0, with sending=0 → d_plus=1, d_minus=0 held for 100 cycles.
- Single byte, data=0x6E, sending=1 for one byte time, CLKS_PER_BIT=8 → per-bit levels K,K,K,K,J,J,J,K, each 8 cycles. Then SE0 for 16 cycles, J for 8 cycles, then idle J.
- Continuous, data=0x6E, sending held high for 50 µs → repeating 16-bit pattern with no gaps. The second byte starts J (bit0=0 toggles from K). No SE0 appears while sending=1.
- Stuffing, data=0xFF continuous → J held for 6 bit periods, then a K stuff bit, then K held for 6 bits, then a J stuff bit, and so on. Each byte period is lengthened accordingly.
- Early stop: drop sending after bit 2 of a byte → remaining 5 bits are sent, then EOP.
- Reset mid-byte: n_rst=1 during bit 4 → J on the next edge; a subsequent sending=1 restarts cleanly from bit 0.
- With D_ORIG_SYNC_EN defined: KJKJKJKK precedes the 0x6E pattern.

Source files
------------

// File: rtl/usb_d_orig_gen.sv
// NRZI bit-stuffing USB-style line driver with EOP generation.
// Optional SYNC preamble: define D_ORIG_SYNC_EN.
module usb_d_orig_gen #(
  parameter int CLKS_PER_BIT = 8,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       sending,
  input  logic [7:0] data,
  output logic       d_plus,
  output logic       d_minus
);

  localparam int TW =
    $clog2(CLKS_PER_BIT * (EOP_SE0_BITS + 1) + 1);
  localparam logic [TW-1:0] BIT_LAST =
    TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] SE0_LAST =
    TW'(CLKS_PER_BIT * EOP_SE0_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SYNC,
    S_SHIFT,
    S_STUFF,
    S_EOP_SE0,
    S_EOP_J
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sr_q, sr_d;
  logic [2:0]    ones_q, ones_d;
  logic          lvl_q, lvl_d;
  logic          dp_q, dp_d;
  logic          dm_q, dm_d;

  logic          bit_end;
  logic [2:0]    nxt_idx;
  logic          tx_go;
  logic          tx_val;

  assign bit_end = (timer_q == BIT_LAST);
  assign nxt_idx = idx_q + 3'd1;
  assign d_plus  = dp_q;
  assign d_minus = dm_q;

  // State and line registers; reset drives idle J.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      sr_q    <= '0;
      ones_q  <= '0;
      lvl_q   <= 1'b1;
      dp_q    <= 1'b1;
      dm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
      ones_q  <= ones_d;
      lvl_q   <= lvl_d;
      dp_q    <= dp_d;
      dm_q    <= dm_d;
    end
  end

  // Next state, bit sequencing, stuffing and NRZI encode.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TW'(1);
    idx_d   = idx_q;
    sr_d    = sr_q;
    ones_d  = ones_q;
    lvl_d   = lvl_q;
    dp_d    = dp_q;
    dm_d    = dm_q;
    tx_go   = 1'b0;
    tx_val  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        idx_d   = '0;
        ones_d  = '0;
        lvl_d   = 1'b1;
        dp_d    = 1'b1;
        dm_d    = 1'b0;
        if (sending) state_d = S_LOAD;
      end
      S_LOAD: begin
        timer_d = '0;
        idx_d   = '0;
        tx_go   = 1'b1;
`ifdef D_ORIG_SYNC_EN
        sr_d    = 8'h80;
        tx_val  = 1'b0;
        state_d = S_SYNC;
`else
        sr_d    = data;
        tx_val  = data[0];
        state_d = S_SHIFT;
`endif
      end
      S_SYNC, S_SHIFT, S_STUFF: begin
        if (bit_end) begin
          timer_d = '0;
          if (ones_q == 3'd6) begin
            state_d = S_STUFF;
            tx_go   = 1'b1;
            tx_val  = 1'b0;
          end else if (idx_q == 3'd7) begin
            if (sending || state_q == S_SYNC) begin
              state_d = S_SHIFT;
              sr_d    = data;
              idx_d   = '0;
              tx_go   = 1'b1;
              tx_val  = data[0];
            end else begin
              state_d = S_EOP_SE0;
              dp_d    = 1'b0;
              dm_d    = 1'b0;
            end
          end else begin
            if (state_q == S_STUFF) state_d = S_SHIFT;
            idx_d  = nxt_idx;
            tx_go  = 1'b1;
            tx_val = sr_q[nxt_idx];
          end
        end
      end
      S_EOP_SE0: begin
        if (timer_q == SE0_LAST) begin
          timer_d = '0;
          state_d = S_EOP_J;
          dp_d    = 1'b1;
          dm_d    = 1'b0;
        end
      end
      S_EOP_J: begin
        if (bit_end) begin
          timer_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (tx_go) begin
      if (tx_val) begin
        lvl_d  = lvl_q;
        ones_d = ones_q + 3'd1;
      end else begin
        lvl_d  = ~lvl_q;
        ones_d = '0;
      end
      dp_d = lvl_d;
      dm_d = ~lvl_d;
    end
  end

endmodule

// File: tb/tb_usb_d_orig_gen.sv
// Self-checking bench for usb_d_orig_gen.
// Per-cycle expected line levels come from a bit-level model.
module tb_usb_d_orig_gen;

  localparam int CPB  = 8;
  localparam int SE0B = 2;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic       sending = 1'b0;
  logic [7:0] data = 8'h00;
  logic       d_plus;
  logic       d_minus;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_q[$];
  logic [7:0] bq[$];

  always #5 clk = ~clk;

  usb_d_orig_gen #(
    .CLKS_PER_BIT(CPB),
    .EOP_SE0_BITS(SE0B)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .sending(sending),
    .data(data),
    .d_plus(d_plus),
    .d_minus(d_minus)
  );

  // Transmit bytes in bq back to back; sending drops
  // drop_bits bit periods into the last byte.
  task automatic run_tx(input string name,
                        input int drop_bits);
    logic       s[$];
    int         bs[$];
    int         starts[$];
    logic [7:0] v;
    logic [1:0] e;
    logic       lvl;
    int         ones;
    int         cyc;
    int         k;
    int         n;
    int         drop_c;
    int         total;
    n = bq.size();
    exp_q.delete();
`ifdef D_ORIG_SYNC_EN
    v = 8'h80;
    for (int i = 0; i < 8; i++) s.push_back(v[i]);
`endif
    for (int j = 0; j < n; j++) begin
      bs.push_back(s.size());
      v = bq[j];
      for (int i = 0; i < 8; i++) s.push_back(v[i]);
    end
    exp_q.push_back(2'b10);
    lvl  = 1'b1;
    ones = 0;
    cyc  = 0;
    k    = 0;
    for (int i = 0; i < s.size(); i++) begin
      if (k < n && i == bs[k]) begin
        starts.push_back(cyc);
        k++;
      end
      if (s[i]) ones++;
      else begin
        lvl  = ~lvl;
        ones = 0;
      end
      repeat (CPB) exp_q.push_back({lvl, ~lvl});
      cyc += CPB;
      if (ones == 6) begin
        lvl  = ~lvl;
        ones = 0;
        repeat (CPB) exp_q.push_back({lvl, ~lvl});
        cyc += CPB;
      end
    end
    repeat (SE0B * CPB) exp_q.push_back(2'b00);
    repeat (CPB) exp_q.push_back(2'b10);
    repeat (4) exp_q.push_back(2'b10);

    drop_c  = 1 + starts[n-1] + drop_bits * CPB;
    total   = exp_q.size();
    data    = bq[0];
    sending = 1'b1;
    for (int c = 0; c < total; c++) begin
      @(posedge clk);
      @(negedge clk);
      for (int j = 0; j < n; j++)
        if (c == 1 + starts[j])
          data = (j + 1 < n) ? bq[j+1]
                             : 8'($urandom);
      if (c == drop_c) sending = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if ({d_plus, d_minus} !== e) begin
        errors++;
        $display("FAIL %s cyc %0d: got %b%b want %b",
                 name, c, d_plus, d_minus, e);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_rst   = 1'b1;
    sending = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      checks++;
      if ({d_plus, d_minus} !== 2'b10) begin
        errors++;
        $display("FAIL reset cyc %0d: got %b%b want 10",
                 c, d_plus, d_minus);
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_single();
    bq = {8'h6E};
    run_tx("single_6e", 0);
  endtask

  task automatic test_back_to_back();
    bq = {8'h6E, 8'h6E, 8'h6E, 8'h6E};
    run_tx("b2b_6e", 0);
    bq = {8'h00, 8'hA5, 8'h3C};
    run_tx("b2b_mix", 5);
  endtask

  task automatic test_stuffing();
    bq = {8'hFF, 8'hFF, 8'hFF};
    run_tx("stuff_ff", 0);
    bq = {8'hF0, 8'hC3};
    run_tx("stuff_cross", 1);
    bq = {8'hFC};
    run_tx("stuff_at_eop", 0);
  endtask

  task automatic test_early_stop();
    bq = {8'h6E, 8'hA5};
    run_tx("early_stop", 2);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      bq.delete();
      repeat (1 + $urandom_range(0, 2))
        bq.push_back(8'($urandom));
      run_tx("random", $urandom_range(0, 7));
    end
  endtask

  task automatic test_reset_mid_byte();
    int off;
    off = 1 + 4 * CPB + 3;
`ifdef D_ORIG_SYNC_EN
    off = off + 8 * CPB;
`endif
    @(negedge clk);
    data    = 8'h00;
    sending = 1'b1;
    repeat (off + 1) @(posedge clk);
    @(negedge clk);
`ifdef D_ORIG_SYNC_EN
    checks++;
    if ({d_plus, d_minus} !== 2'b10) begin
      errors++;
      $display("FAIL midrst_pre: got %b%b want 10",
               d_plus, d_minus);
    end
`else
    checks++;
    if ({d_plus, d_minus} !== 2'b01) begin
      errors++;
      $display("FAIL midrst_pre: got %b%b want 01",
               d_plus, d_minus);
    end
`endif
    sending = 1'b0;
    n_rst   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({d_plus, d_minus} !== 2'b10) begin
      errors++;
      $display("FAIL midrst_j: got %b%b want 10",
               d_plus, d_minus);
    end
    n_rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({d_plus, d_minus} !== 2'b10) begin
        errors++;
        $display("FAIL midrst_idle: got %b%b want 10",
                 d_plus, d_minus);
      end
    end
    bq = {8'h6E};
    run_tx("after_reset", 0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stuffing();
    test_early_stop();
    test_random();
    test_reset_mid_byte();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
